// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-add cell stepped LSB first over WIDTH cycles.
// Optional subtract mode (port sub) is enabled by defining SERIAL_ADDER_SUB_EN.

module half_adder_1bit (
  output logic y,
  output logic c,
  input  logic a,
  input  logic b
);
  assign y = a ^ b;
  assign c = a & b;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;

  logic               p_bit, g0, g1, s_bit, carry_n;
  logic               last_bit;
  logic               sub_mode;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_mode = sub;
`else
  assign sub_mode = 1'b0;
`endif

  // Full-add cell: two half adders with the carries ORed.
  half_adder_1bit u_ha0 (.y(p_bit), .c(g0), .a(opa_q[0]), .b(opb_q[0]));
  half_adder_1bit u_ha1 (.y(s_bit), .c(g1), .a(p_bit),    .b(carry_q));
  assign carry_n  = g0 | g1;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // Subtraction loads ~b with carry-in 1 so the same cell computes a - b.
  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = sub_mode ? ~b : b;
          carry_d = sub_mode;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
        end
      end
      RUN: begin
        opa_d            = opa_q >> 1;
        opb_d            = opb_q >> 1;
        carry_d          = carry_n;
        cnt_d            = cnt_q + CNT_W'(1);
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = s_bit;
        if (last_bit) cout_d = carry_n;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
    cout = cout_q;
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8 instance plus a WIDTH=1 instance).
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif

  logic       start1;
  logic [0:0] a1, b1, sum1;
  logic       busy1, done1, cout1;

  int total = 0;
  int bad   = 0;

  logic [8:0] q[$];
  logic [1:0] q1[$];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [7:0] av, input logic [7:0] bv, input bit s);
    logic [8:0] e;
    e = s ? ({1'b0, av} + {1'b0, ~bv} + 9'd1) : ({1'b0, av} + {1'b0, bv});
    a = av;
    b = bv;
`ifdef SERIAL_ADDER_SUB_EN
    sub = s;
`endif
    start = 1'b1;
    q.push_back(e);
  endtask

  // Called one step after the accepting edge; returns at the done cycle.
  task automatic collect(input string tag);
    int cyc = 0;
    int bc  = 0;
    int both = 0;
    logic [8:0] e;
    while (!done && cyc < 40) begin
      if (busy) bc++;
      if (busy && done) both++;
      tick();
      cyc++;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_busy_cycles"}, bc, 8);
    check({tag, "_busy_done_overlap"}, both, 0);
    check({tag, "_busy_in_done"}, busy, 0);
    if (q.size() > 0) e = q.pop_front();
    else e = 9'bx;
    check({tag, "_sum"}, sum, e[7:0]);
    check({tag, "_cout"}, cout, e[8]);
  endtask

  initial begin
    int seen;
    logic [1:0] e1;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst = 1'b0;
    tick();

    // 1: basic add with one-cycle done pulse
    drive_start(8'h35, 8'h4A, 1'b0);
    tick(); start = 1'b0;
    check("t1_busy_after_accept", busy, 1);
    collect("t1");
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_idle_busy", busy, 0);

    // 2: overflow, result holds in IDLE
    drive_start(8'hFF, 8'h01, 1'b0);
    tick(); start = 1'b0;
    collect("t2");
    repeat (3) tick();
    check("t2_hold_sum", sum, 8'h00);
    check("t2_hold_cout", cout, 1);

    // 3: start held through RUN, operands changed; re-accept at E0+WIDTH+2
    drive_start(8'h12, 8'h34, 1'b0);
    tick();
    a = 8'h00; b = 8'h00;
    q.push_back(9'h000);
    collect("t3");
    tick();
    check("t3_idle_gap_busy", busy, 0);
    check("t3_idle_gap_sum", sum, 8'h46);
    tick();
    check("t3_reaccept", busy, 1);
    start = 1'b0;
    collect("t3b");
    tick();

    // 4: async reset in RUN cycle 4 discards the operation
    a = 8'h55; b = 8'h55; start = 1'b1;
    tick(); start = 1'b0;
    repeat (3) tick();
    check("t4_busy_before_rst", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_busy", busy, 0);
    check("t4_rst_done", done, 0);
    check("t4_rst_sum", sum, 0);
    check("t4_rst_cout", cout, 0);
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      tick();
      if (done || busy) seen++;
    end
    check("t4_no_done_after_rst", seen, 0);
    drive_start(8'h0F, 8'h01, 1'b0);
    tick(); start = 1'b0;
    collect("t4");
    tick();

`ifdef SERIAL_ADDER_SUB_EN
    // 5: subtraction
    drive_start(8'h10, 8'h01, 1'b1);
    tick(); start = 1'b0;
    collect("t5a");
    tick();
    drive_start(8'h01, 8'h02, 1'b1);
    tick(); start = 1'b0;
    collect("t5b");
    tick();
    sub = 1'b0;
`endif

    // 6: WIDTH=1 exhaustive
    for (int ai = 0; ai < 2; ai++) begin
      for (int bi = 0; bi < 2; bi++) begin
        a1 = ai[0:0]; b1 = bi[0:0]; start1 = 1'b1;
        q1.push_back(2'(ai + bi));
        tick(); start1 = 1'b0;
        check("t6_busy", busy1, 1);
        tick();
        check("t6_busy_end", busy1, 0);
        check("t6_done", done1, 1);
        if (q1.size() > 0) e1 = q1.pop_front();
        else e1 = 2'bx;
        check("t6_sum", sum1, e1[0]);
        check("t6_cout", cout1, e1[1]);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
